// File: rtl/irq_ctrl.sv
// irq_ctrl -- fixed-priority interrupt controller with in-service nesting.
//
// Latches peripheral requests (rising-edge or level per source), masks them,
// and arbitrates by fixed priority (index 0 highest). Higher-priority sources
// can nest above one already in service. The CPU claims the current grant
// with an ACK write and retires the highest-priority in-service source with
// an EOI write.
//
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset
//   irq_src  raw interrupt requests, synchronous to clk
//   Addr     register word address
//   WE       one-cycle write strobe
//   Din      write data
//   Dout     read data, combinational from Addr and register state
//   HWInt    registered one-hot of the granted source
//   irq      registered OR of HWInt
//
// Register map: 0 PEND (RO), 1 MASK (RW), 2 CLR (W1C, edge sources),
//   3 ID (RO, bit31 valid, [2:0] index), 4 ACK (WO), 5 EOI (WO),
//   6 INSERV (RO), 7 reserved (reads 0).
module irq_ctrl #(
    parameter int               N_SRC     = 6,
    parameter logic [N_SRC-1:0] EDGE_MASK = {N_SRC{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [2:0]       Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    output logic [31:0]      Dout,
    output logic [N_SRC-1:0] HWInt,
    output logic             irq
);

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pend_q,   pend_d;
    logic [N_SRC-1:0] mask_q,   mask_d;
    logic [N_SRC-1:0] inserv_q, inserv_d;
    logic [N_SRC-1:0] hwint_q,  hwint_d;
    logic             irq_q,    irq_d;

    logic [N_SRC-1:0] set_edge;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] grant_oh;
    logic [N_SRC-1:0] ack_oh;
    logic [N_SRC-1:0] lowest_inserv_oh;
    logic [2:0]       id;
    logic             valid;
    logic             ack;
    logic             eoi;
    int               top;

    logic unused_din;
    assign unused_din = ^Din[31:N_SRC];

    assign set_edge = irq_src & ~src_q;
    assign clr      = (WE && Addr == 3'd2) ? Din[N_SRC-1:0] : '0;
    assign eoi      = WE && (Addr == 3'd5);
    assign ack      = WE && (Addr == 3'd4) && valid;
    assign ack_oh   = ack ? grant_oh : '0;

    // top is the priority level currently in service; only strictly
    // higher-priority (lower-index) sources may be granted above it.
    always_comb begin
        top              = N_SRC;
        lowest_inserv_oh = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (inserv_q[i]) begin
                top              = i;
                lowest_inserv_oh = '0;
                lowest_inserv_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_SRC; i++) begin
            eligible[i] = pend_q[i] & mask_q[i] & (i < top);
        end
        valid    = |eligible;
        id       = '0;
        grant_oh = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                id          = 3'(i);
                grant_oh    = '0;
                grant_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            if (EDGE_MASK[i]) begin
                // A new edge wins over a simultaneous CLR or ACK.
                pend_d[i] = (pend_q[i] & ~clr[i] & ~ack_oh[i]) | set_edge[i];
            end else begin
                pend_d[i] = irq_src[i];
            end
        end
        mask_d   = (WE && Addr == 3'd1) ? Din[N_SRC-1:0] : mask_q;
        inserv_d = (inserv_q | ack_oh) & ~(eoi ? lowest_inserv_oh : '0);
        // The claimed request is withdrawn on the ACK edge itself.
        hwint_d  = ack ? '0 : grant_oh;
        irq_d    = |hwint_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q    <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            inserv_q <= '0;
            hwint_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            src_q    <= irq_src;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            inserv_q <= inserv_d;
            hwint_q  <= hwint_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr)
            3'd0:    Dout[N_SRC-1:0] = pend_q;
            3'd1:    Dout[N_SRC-1:0] = mask_q;
            3'd3:    Dout = {valid, 28'd0, id};
            3'd6:    Dout[N_SRC-1:0] = inserv_q;
            default: Dout = '0;
        endcase
    end

    assign HWInt = hwint_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  irq_src;
    logic [2:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  HWInt;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    string       nm_q[$];

    irq_ctrl #(.N_SRC(6), .EDGE_MASK(6'h1F)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src), .Addr(Addr), .WE(WE),
        .Din(Din), .Dout(Dout), .HWInt(HWInt), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        Addr = a; Din = d; WE = 1'b1;
        tick();
        WE = 1'b0; Addr = 3'd0; Din = '0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        Addr = a;
        #1;
        v = Dout;
    endtask

    task automatic pulse(input logic [5:0] m);
        irq_src = irq_src | m;
        tick();
        irq_src = irq_src & ~m;
    endtask

    // Records one observation; comparison happens in each test's drain loop.
    task automatic note(input string n, input logic [31:0] g);
        nm_q.push_back(n);
        got_q.push_back(g);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        wr(3'd1, 32'h3F);
        pulse(6'h04);
        tick();
        exp_q.push_back(32'h04); note("pre_reset_hwint", {26'd0, HWInt});
        #3 reset = 1'b1;
        #1;
        exp_q.push_back(0); note("reset_hwint", {26'd0, HWInt});
        exp_q.push_back(0); note("reset_irq", {31'd0, irq});
        for (int a = 0; a < 8; a++) begin
            exp_q.push_back(0);
            rd(3'(a), v);
            note($sformatf("reset_reg%0d", a), v);
        end
        @(negedge clk) reset = 1'b0;
        tick();
        exp_q.push_back(0); note("post_reset_mask", 0);
        rd(3'd1, v); got_q[got_q.size()-1] = v;
        while (exp_q.size() > 0) begin
            logic [31:0] e, g; string n;
            e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", n, g, e); n_fail++; end
        end
    endtask

    task automatic test_single();
        logic [31:0] v;
        wr(3'd1, 32'h3F);
        pulse(6'h02);
        exp_q.push_back(32'h02); rd(3'd0, v); note("single_pend", v);
        exp_q.push_back(0); note("single_hwint_early", {26'd0, HWInt});
        tick();
        exp_q.push_back(32'h02); note("single_hwint", {26'd0, HWInt});
        exp_q.push_back(1); note("single_irq", {31'd0, irq});
        exp_q.push_back(32'h8000_0001); rd(3'd3, v); note("single_id", v);
        wr(3'd4, 32'h0);
        exp_q.push_back(32'h02); rd(3'd6, v); note("single_inserv", v);
        exp_q.push_back(0); rd(3'd0, v); note("single_pend_acked", v);
        exp_q.push_back(0); rd(3'd3, v); note("single_id_none", v);
        wr(3'd5, 32'h0);
        exp_q.push_back(0); rd(3'd6, v); note("single_inserv_eoi", v);
        while (exp_q.size() > 0) begin
            logic [31:0] e, g; string n;
            e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", n, g, e); n_fail++; end
        end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        pulse(6'h0A);
        tick();
        exp_q.push_back(32'h02); note("prio_hwint_first", {26'd0, HWInt});
        wr(3'd4, 32'h0);
        exp_q.push_back(32'h02); rd(3'd6, v); note("prio_inserv", v);
        tick();
        exp_q.push_back(0); note("prio_hwint_blocked", {26'd0, HWInt});
        exp_q.push_back(32'h08); rd(3'd0, v); note("prio_pend_left", v);
        wr(3'd5, 32'h0);
        exp_q.push_back(0); rd(3'd6, v); note("prio_inserv_eoi", v);
        tick();
        exp_q.push_back(32'h08); note("prio_hwint_second", {26'd0, HWInt});
        exp_q.push_back(32'h8000_0003); rd(3'd3, v); note("prio_id_second", v);
        while (exp_q.size() > 0) begin
            logic [31:0] e, g; string n;
            e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", n, g, e); n_fail++; end
        end
    endtask

    // Entered with src3 pending and granted.
    task automatic test_nesting();
        logic [31:0] v;
        wr(3'd4, 32'h0);
        exp_q.push_back(32'h08); rd(3'd6, v); note("nest_inserv3", v);
        pulse(6'h01);
        tick();
        exp_q.push_back(32'h01); note("nest_hwint0", {26'd0, HWInt});
        wr(3'd4, 32'h0);
        exp_q.push_back(32'h09); rd(3'd6, v); note("nest_inserv9", v);
        wr(3'd5, 32'h0);
        exp_q.push_back(32'h08); rd(3'd6, v); note("nest_eoi_first", v);
        wr(3'd5, 32'h0);
        exp_q.push_back(0); rd(3'd6, v); note("nest_eoi_second", v);
        tick();
        exp_q.push_back(0); note("nest_hwint_idle", {26'd0, HWInt});
        while (exp_q.size() > 0) begin
            logic [31:0] e, g; string n;
            e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", n, g, e); n_fail++; end
        end
    endtask

    task automatic test_clr_race();
        logic [31:0] v;
        pulse(6'h04);
        tick();
        exp_q.push_back(32'h04); note("race_hwint", {26'd0, HWInt});
        irq_src[2] = 1'b1; Addr = 3'd2; Din = 32'h04; WE = 1'b1;
        tick();
        WE = 1'b0; irq_src[2] = 1'b0;
        exp_q.push_back(32'h04); rd(3'd0, v); note("race_pend_kept", v);
        wr(3'd1, 32'h0);
        tick();
        exp_q.push_back(0); note("masked_hwint", {26'd0, HWInt});
        exp_q.push_back(0); note("masked_irq", {31'd0, irq});
        exp_q.push_back(32'h04); rd(3'd0, v); note("masked_pend", v);
        exp_q.push_back(0); rd(3'd3, v); note("masked_id", v);
        wr(3'd2, 32'h04);
        exp_q.push_back(0); rd(3'd0, v); note("clr_pend", v);
        wr(3'd1, 32'h3F);
        while (exp_q.size() > 0) begin
            logic [31:0] e, g; string n;
            e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", n, g, e); n_fail++; end
        end
    endtask

    task automatic test_misc();
        logic [31:0] v;
        wr(3'd4, 32'h0);
        exp_q.push_back(0); rd(3'd6, v); note("ack_no_grant", v);
        wr(3'd5, 32'h0);
        exp_q.push_back(0); rd(3'd6, v); note("eoi_idle", v);
        wr(3'd7, 32'hFFFF_FFFF);
        exp_q.push_back(0); rd(3'd7, v); note("reg7_read", v);
        exp_q.push_back(32'h3F); rd(3'd1, v); note("mask_after_reg7", v);
        while (exp_q.size() > 0) begin
            logic [31:0] e, g; string n;
            e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", n, g, e); n_fail++; end
        end
    endtask

    task automatic test_level();
        logic [31:0] v;
        irq_src[5] = 1'b1;
        tick();
        exp_q.push_back(32'h20); rd(3'd0, v); note("level_pend", v);
        tick();
        exp_q.push_back(32'h20); note("level_hwint", {26'd0, HWInt});
        exp_q.push_back(32'h8000_0005); rd(3'd3, v); note("level_id", v);
        wr(3'd4, 32'h0);
        exp_q.push_back(32'h20); rd(3'd6, v); note("level_inserv", v);
        exp_q.push_back(32'h20); rd(3'd0, v); note("level_pend_after_ack", v);
        exp_q.push_back(0); note("level_hwint_acked", {26'd0, HWInt});
        wr(3'd5, 32'h0);
        tick();
        exp_q.push_back(32'h20); note("level_regrant", {26'd0, HWInt});
        irq_src[5] = 1'b0;
        tick();
        exp_q.push_back(0); rd(3'd0, v); note("level_pend_drop", v);
        tick();
        exp_q.push_back(0); note("level_hwint_drop", {26'd0, HWInt});
        exp_q.push_back(0); note("level_irq_drop", {31'd0, irq});
        while (exp_q.size() > 0) begin
            logic [31:0] e, g; string n;
            e = exp_q.pop_front(); g = got_q.pop_front(); n = nm_q.pop_front();
            n_checks++;
            if (g !== e) begin $display("FAIL %s: got %h expected %h", n, g, e); n_fail++; end
        end
    endtask

    initial begin
        reset = 1'b1; irq_src = '0; Addr = '0; WE = 1'b0; Din = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        tick();
        test_reset();
        test_single();
        test_priority();
        test_nesting();
        test_clr_race();
        test_misc();
        test_level();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
